// File: rtl/freq_monitor_pkg.sv
// Shared encodings and default-threshold helper
// for the multi-channel frequency monitor.
package freq_monitor_pkg;

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_MATCH   = 2'd1;
  localparam logic [1:0] ST_HIGH    = 2'd2;
  localparam logic [1:0] ST_LOW     = 2'd3;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ACQ,
    CH_LOCKED,
    CH_TIMEOUT
  } ch_state_e;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
  } thr64_t;

  // Wide arithmetic; the caller saturates hi to its own width
  function automatic thr64_t default_thr(
    input longint unsigned expected,
    input longint unsigned pct
  );
    longint unsigned tol;
    thr64_t t;
    tol  = expected * pct / 64'd100;
    t.lo = (tol > expected) ? 64'd0 : expected - tol;
    t.hi = expected + tol;
    return t;
  endfunction

endpackage

// File: rtl/freq_monitor_ch.sv
// One monitored channel: thresholds, classifier,
// lock/unlock hysteresis FSM and watchdog.
module freq_monitor_ch
  import freq_monitor_pkg::*;
#(
  parameter int                FREQ_W         = 32,
  parameter logic [FREQ_W-1:0] DEF_MIN        = '0,
  parameter logic [FREQ_W-1:0] DEF_MAX        = '1,
  parameter int                LOCK_COUNT     = 4,
  parameter int                UNLOCK_COUNT   = 2,
  parameter int                TIMEOUT_CYCLES = 60_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] meas_freq,
  input  logic              meas_valid,
  input  logic              cfg_wr,
  input  logic [FREQ_W-1:0] cfg_expected,
  input  logic [FREQ_W-1:0] cfg_tol,
  output logic [1:0]        status,
  output logic              locked,
  output logic              timeout,
  output logic              lock_evt
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [MC_W-1:0] MC_LIM = MC_W'(LOCK_COUNT);
  localparam logic [MS_W-1:0] MS_LIM = MS_W'(UNLOCK_COUNT);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES);

  logic [FREQ_W-1:0] thr_min;
  logic [FREQ_W-1:0] thr_max;
  logic [FREQ_W-1:0] cfg_min;
  logic [FREQ_W-1:0] cfg_max;
  logic [FREQ_W:0]   lo_diff;
  logic [FREQ_W:0]   hi_sum;

  ch_state_e         state;
  ch_state_e         state_n;
  logic [1:0]        status_n;
  logic              locked_n;
  logic              timeout_n;
  logic              lock_evt_n;
  logic [MC_W-1:0]   match_cnt;
  logic [MC_W-1:0]   match_n;
  logic [MS_W-1:0]   miss_cnt;
  logic [MS_W-1:0]   miss_n;
  logic [WD_W-1:0]   wd_cnt;
  logic [WD_W-1:0]   wd_n;
  logic [1:0]        cls;
  logic              is_match;

  // Carry/borrow bit drives the saturation of each bound
  assign lo_diff = {1'b0, cfg_expected} - {1'b0, cfg_tol};
  assign hi_sum  = {1'b0, cfg_expected} + {1'b0, cfg_tol};
  assign cfg_min = lo_diff[FREQ_W] ? '0 : lo_diff[FREQ_W-1:0];
  assign cfg_max = hi_sum[FREQ_W]  ? '1 : hi_sum[FREQ_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_min <= DEF_MIN;
      thr_max <= DEF_MAX;
    end else if (cfg_wr) begin
      thr_min <= cfg_min;
      thr_max <= cfg_max;
    end
  end

  // min <= max always holds, so the two range tests are exclusive
  always_comb begin
    cls = ST_MATCH;
    unique case (1'b1)
      (meas_freq > thr_max): cls = ST_HIGH;
      (meas_freq < thr_min): cls = ST_LOW;
      default:               cls = ST_MATCH;
    endcase
  end

  assign is_match = (cls == ST_MATCH);

  always_comb begin
    state_n    = state;
    status_n   = status;
    locked_n   = locked;
    timeout_n  = timeout;
    lock_evt_n = 1'b0;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    if (meas_valid)
      wd_n = '0;
    else if (wd_cnt == WD_LIM)
      wd_n = wd_cnt;
    else
      wd_n = wd_cnt + WD_W'(1);

    if (cfg_wr) begin
      state_n    = CH_IDLE;
      status_n   = ST_UNKNOWN;
      locked_n   = 1'b0;
      timeout_n  = 1'b0;
      lock_evt_n = locked;
      match_n    = '0;
      miss_n     = '0;
      wd_n       = '0;
    end else if (meas_valid) begin
      status_n  = cls;
      timeout_n = 1'b0;
      if (state == CH_LOCKED) begin
        if (is_match) begin
          miss_n = '0;
        end else if (miss_cnt + MS_W'(1) == MS_LIM) begin
          state_n    = CH_ACQ;
          locked_n   = 1'b0;
          lock_evt_n = 1'b1;
          match_n    = '0;
          miss_n     = '0;
        end else begin
          miss_n = miss_cnt + MS_W'(1);
        end
      end else begin
        // IDLE and TIMEOUT treat the sample exactly like ACQ
        state_n = CH_ACQ;
        if (!is_match) begin
          match_n = '0;
        end else if (match_cnt + MC_W'(1) == MC_LIM) begin
          state_n    = CH_LOCKED;
          locked_n   = 1'b1;
          lock_evt_n = 1'b1;
          match_n    = '0;
          miss_n     = '0;
        end else begin
          match_n = match_cnt + MC_W'(1);
        end
      end
    end else if (wd_n == WD_LIM &&
                 (state == CH_ACQ || state == CH_LOCKED)) begin
      state_n    = CH_TIMEOUT;
      status_n   = ST_UNKNOWN;
      locked_n   = 1'b0;
      timeout_n  = 1'b1;
      lock_evt_n = locked;
      match_n    = '0;
      miss_n     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CH_IDLE;
      status    <= ST_UNKNOWN;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      lock_evt  <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      wd_cnt    <= '0;
    end else begin
      state     <= state_n;
      status    <= status_n;
      locked    <= locked_n;
      timeout   <= timeout_n;
      lock_evt  <= lock_evt_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      wd_cnt    <= wd_n;
    end
  end

endmodule

// File: rtl/freq_monitor_multi.sv
// Multi-channel frequency monitor: per-channel
// classification, lock hysteresis and watchdog.
module freq_monitor_multi
  import freq_monitor_pkg::*;
#(
  parameter int              NUM_CH            = 4,
  parameter int              FREQ_W            = 32,
  parameter longint unsigned EXPECTED_FREQ     = 54_000_000,
  parameter longint unsigned TOLERANCE_PERCENT = 1,
  parameter int              LOCK_COUNT        = 4,
  parameter int              UNLOCK_COUNT      = 2,
  parameter int              TIMEOUT_CYCLES    = 60_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*FREQ_W-1:0] meas_freq,
  input  logic [NUM_CH-1:0]        meas_valid,
  input  logic                     cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [FREQ_W-1:0]        cfg_expected,
  input  logic [FREQ_W-1:0]        cfg_tol,
  output logic [2*NUM_CH-1:0]      ch_status,
  output logic [NUM_CH-1:0]        ch_locked,
  output logic [NUM_CH-1:0]        ch_timeout,
  output logic [NUM_CH-1:0]        lock_evt,
  output logic                     all_locked
);

  localparam int     CH_W    = $clog2(NUM_CH);
  localparam thr64_t DEF_THR =
    default_thr(EXPECTED_FREQ, TOLERANCE_PERCENT);
  localparam logic [FREQ_W-1:0] DEF_MIN =
    FREQ_W'(DEF_THR.lo);
  localparam logic [FREQ_W-1:0] DEF_MAX =
    ((DEF_THR.hi >> FREQ_W) != 64'd0) ? '1 : FREQ_W'(DEF_THR.hi);

  logic [NUM_CH-1:0] cfg_sel;

  // Addresses at or above NUM_CH select no channel
  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      cfg_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_monitor_ch #(
      .FREQ_W         (FREQ_W),
      .DEF_MIN        (DEF_MIN),
      .DEF_MAX        (DEF_MAX),
      .LOCK_COUNT     (LOCK_COUNT),
      .UNLOCK_COUNT   (UNLOCK_COUNT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .meas_freq    (meas_freq[g*FREQ_W +: FREQ_W]),
      .meas_valid   (meas_valid[g]),
      .cfg_wr       (cfg_sel[g]),
      .cfg_expected (cfg_expected),
      .cfg_tol      (cfg_tol),
      .status       (ch_status[2*g +: 2]),
      .locked       (ch_locked[g]),
      .timeout      (ch_timeout[g]),
      .lock_evt     (lock_evt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      all_locked <= 1'b0;
    else
      all_locked <= &ch_locked;
  end

endmodule

// File: tb/tb_freq_monitor_multi.sv
// Directed bench for freq_monitor_multi
// with hand-computed expectations.
module tb_freq_monitor_multi;

  localparam int NCH = 4;
  localparam int FW  = 32;
  localparam logic [31:0] F_NOM = 32'd54_000_000;

  logic            clk;
  logic            rst_n;
  logic [NCH*FW-1:0] meas_freq;
  logic [NCH-1:0]  meas_valid;
  logic            cfg_wr;
  logic [1:0]      cfg_ch;
  logic [FW-1:0]   cfg_expected;
  logic [FW-1:0]   cfg_tol;
  logic [2*NCH-1:0] ch_status;
  logic [NCH-1:0]  ch_locked;
  logic [NCH-1:0]  ch_timeout;
  logic [NCH-1:0]  lock_evt;
  logic            all_locked;

  int n_cmp = 0;
  int n_bad = 0;

  freq_monitor_multi #(
    .NUM_CH         (NCH),
    .FREQ_W         (FW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .meas_freq    (meas_freq),
    .meas_valid   (meas_valid),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_expected (cfg_expected),
    .cfg_tol      (cfg_tol),
    .ch_status    (ch_status),
    .ch_locked    (ch_locked),
    .ch_timeout   (ch_timeout),
    .lock_evt     (lock_evt),
    .all_locked   (all_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] st(input int ch);
    return ch_status[2*ch +: 2];
  endfunction

  task automatic send(input int ch, input logic [31:0] f);
    meas_freq[ch*FW +: FW] = f;
    meas_valid[ch] = 1'b1;
    @(negedge clk);
    meas_valid = '0;
  endtask

  task automatic send_all(input logic [31:0] f);
    for (int i = 0; i < NCH; i++) meas_freq[i*FW +: FW] = f;
    meas_valid = '1;
    @(negedge clk);
    meas_valid = '0;
  endtask

  task automatic cfg(input int ch, input logic [31:0] e, input logic [31:0] t);
    cfg_wr = 1'b1;
    cfg_ch = 2'(ch);
    cfg_expected = e;
    cfg_tol = t;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    n_cmp++;
    if ({ch_status, ch_locked, ch_timeout, lock_evt, all_locked} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got st=%h lk=%h to=%h ev=%h al=%b want all 0",
               ch_status, ch_locked, ch_timeout, lock_evt, all_locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lock;
    send(0, F_NOM);
    n_cmp++;
    if (st(0) !== 2'd1 || ch_locked[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_first got st=%0d lk=%b want st=1 lk=0", st(0), ch_locked[0]);
    end
    send(0, F_NOM);
    send(0, F_NOM);
    n_cmp++;
    if (ch_locked[0] !== 1'b0 || lock_evt[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_third got lk=%b ev=%b want 0 0", ch_locked[0], lock_evt[0]);
    end
    send(0, F_NOM);
    n_cmp++;
    if (ch_locked !== 4'b0001 || lock_evt !== 4'b0001 || all_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_fourth got lk=%b ev=%b al=%b want 0001 0001 0",
               ch_locked, lock_evt, all_locked);
    end
    @(negedge clk);
    n_cmp++;
    if (ch_locked[0] !== 1'b1 || lock_evt[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_evt_single got lk=%b ev=%b want 1 0", ch_locked[0], lock_evt[0]);
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] f [4] = '{32'd53_460_000, 32'd53_459_999,
                           32'd54_540_000, 32'd54_540_001};
    logic [1:0]  e [4] = '{2'd1, 2'd3, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      send(0, f[i]);
      n_cmp++;
      if (st(0) !== e[i] || ch_locked[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL boundary_%0d f=%0d got st=%0d lk=%b want st=%0d lk=1",
                 i, f[i], st(0), ch_locked[0], e[i]);
      end
    end
  endtask

  task automatic test_hysteresis;
    send(0, F_NOM);
    send(0, 32'd60_000_000);
    send(0, F_NOM);
    n_cmp++;
    if (ch_locked[0] !== 1'b1 || st(0) !== 2'd1) begin
      n_bad++;
      $display("FAIL hyst_single_bad got lk=%b st=%0d want 1 1", ch_locked[0], st(0));
    end
    send(0, 32'd50_000_000);
    n_cmp++;
    if (ch_locked[0] !== 1'b1 || lock_evt[0] !== 1'b0 || st(0) !== 2'd3) begin
      n_bad++;
      $display("FAIL hyst_first_bad got lk=%b ev=%b st=%0d want 1 0 3",
               ch_locked[0], lock_evt[0], st(0));
    end
    send(0, 32'd50_000_000);
    n_cmp++;
    if (ch_locked[0] !== 1'b0 || lock_evt[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL hyst_unlock got lk=%b ev=%b want 0 1", ch_locked[0], lock_evt[0]);
    end
  endtask

  task automatic test_reprogram;
    repeat (4) send(2, F_NOM);
    n_cmp++;
    if (ch_locked[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL reprog_prelock got lk=%b want 1", ch_locked[2]);
    end
    cfg(2, 32'd100, 32'd200);
    n_cmp++;
    if (ch_locked[2] !== 1'b0 || lock_evt[2] !== 1'b1 || st(2) !== 2'd0) begin
      n_bad++;
      $display("FAIL reprog_idle got lk=%b ev=%b st=%0d want 0 1 0",
               ch_locked[2], lock_evt[2], st(2));
    end
    send(2, 32'd0);
    n_cmp++;
    if (st(2) !== 2'd1) begin
      n_bad++;
      $display("FAIL reprog_min0 got st=%0d want 1", st(2));
    end
    send(2, 32'd300);
    n_cmp++;
    if (st(2) !== 2'd1) begin
      n_bad++;
      $display("FAIL reprog_max300 got st=%0d want 1", st(2));
    end
    send(2, 32'd301);
    n_cmp++;
    if (st(2) !== 2'd2) begin
      n_bad++;
      $display("FAIL reprog_301 got st=%0d want 2", st(2));
    end
  endtask

  task automatic test_watchdog;
    repeat (4) send(1, F_NOM);
    repeat (15) @(negedge clk);
    n_cmp++;
    if (ch_timeout[1] !== 1'b0 || ch_locked[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_15 got to=%b lk=%b want 0 1", ch_timeout[1], ch_locked[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (ch_timeout[1] !== 1'b1 || ch_locked[1] !== 1'b0 ||
        lock_evt[1] !== 1'b1 || st(1) !== 2'd0) begin
      n_bad++;
      $display("FAIL wd_16 got to=%b lk=%b ev=%b st=%0d want 1 0 1 0",
               ch_timeout[1], ch_locked[1], lock_evt[1], st(1));
    end
    send(1, F_NOM);
    n_cmp++;
    if (ch_timeout[1] !== 1'b0 || st(1) !== 2'd1 || ch_locked[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_recover got to=%b st=%0d lk=%b want 0 1 0",
               ch_timeout[1], st(1), ch_locked[1]);
    end
  endtask

  task automatic test_concurrency;
    cfg(2, F_NOM, 32'd540_000);
    repeat (4) send_all(F_NOM);
    n_cmp++;
    if (ch_locked !== 4'hf) begin
      n_bad++;
      $display("FAIL conc_all_lock got lk=%b want 1111", ch_locked);
    end
    @(negedge clk);
    n_cmp++;
    if (all_locked !== 1'b1) begin
      n_bad++;
      $display("FAIL conc_all_locked got %b want 1", all_locked);
    end
    cfg_wr = 1'b1;
    cfg_ch = 2'd3;
    cfg_expected = F_NOM;
    cfg_tol = 32'd540_000;
    for (int i = 0; i < NCH; i++) meas_freq[i*FW +: FW] = F_NOM;
    meas_valid = '1;
    @(negedge clk);
    cfg_wr = 1'b0;
    meas_valid = '0;
    n_cmp++;
    if (ch_locked !== 4'b0111 || lock_evt !== 4'b1000 ||
        st(3) !== 2'd0 || st(0) !== 2'd1 || ch_timeout !== 4'b0000) begin
      n_bad++;
      $display("FAIL conc_cfg_wins got lk=%b ev=%b st3=%0d st0=%0d to=%b want 0111 1000 0 1 0000",
               ch_locked, lock_evt, st(3), st(0), ch_timeout);
    end
    @(negedge clk);
    n_cmp++;
    if (all_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL conc_all_drop got %b want 0", all_locked);
    end
    repeat (3) send(3, F_NOM);
    n_cmp++;
    if (ch_locked[3] !== 1'b0 || st(3) !== 2'd1) begin
      n_bad++;
      $display("FAIL conc_dropped got lk=%b st=%0d want 0 1", ch_locked[3], st(3));
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ch_status, ch_locked, ch_timeout, lock_evt, all_locked} !== '0) begin
      n_bad++;
      $display("FAIL conc_async_reset got st=%h lk=%h to=%h ev=%h al=%b want all 0",
               ch_status, ch_locked, ch_timeout, lock_evt, all_locked);
    end
  endtask

  initial begin
    meas_freq = '0;
    meas_valid = '0;
    cfg_wr = 1'b0;
    cfg_ch = '0;
    cfg_expected = '0;
    cfg_tol = '0;
    test_reset;
    test_lock;
    test_boundaries;
    test_hysteresis;
    test_reprogram;
    test_watchdog;
    test_concurrency;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
